mips_io_responder: RTL and testbench



---
 rtl/mips_io_responder_pkg.sv | 21 ++
 rtl/mips_io_responder_if.sv | 19 +
 rtl/mips_io_responder_tx_fifo.sv | 49 ++++
 rtl/mips_io_responder.sv | 117 +++++++++++
 tb/tb_mips_io_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_io_responder_pkg.sv
// Shared constants for the memory-mapped I/O responder: register offsets,
// STATUS bit positions and the default window base.
package mips_io_pkg;

  typedef enum logic [1:0] {
    OFF_PORT_OUT = 2'd0,
    OFF_PORT_IN  = 2'd1,
    OFF_STATUS   = 2'd2,
    OFF_TX_DATA  = 2'd3
  } io_off_e;

  localparam int STAT_IN_CHANGED = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_EMPTY      = 2;
  localparam int STAT_OVERFLOW   = 3;
  localparam int STAT_COUNT_LSB  = 4;
  localparam int STAT_COUNT_W    = 4;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1001_0000;

endpackage

// File: rtl/mips_io_responder_if.sv
// CPU data-memory bus as seen by a memory-mapped slave.
interface mips_io_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );
endinterface

// File: rtl/mips_io_responder_tx_fifo.sv
// First-word-fall-through transmit FIFO; a push into a full FIFO is still
// accepted when a pop happens on the same edge.
module io_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_push_rej,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_full     = (o_count == DEPTH_CNT);
  assign o_empty    = (o_count == '0);
  assign o_data     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop_ok   = i_pop & ~o_empty;
  assign w_push_ok  = i_push & (~o_full | w_pop_ok);
  assign o_push_rej = i_push & ~w_push_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end
endmodule

// File: rtl/mips_io_responder.sv
// Memory-mapped I/O slave: PORT_OUT/PORT_IN registers, sticky STATUS with
// clear-on-read, and a TX FIFO drained by a valid/ready consumer.
module mips_io_responder
  import mips_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TX_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  mips_io_responder_if.slave  bus,
  input  logic [7:0]          PortIn,
  output logic [31:0]         PortOut,
  output logic [TX_WIDTH-1:0] TxData,
  output logic                TxValid,
  input  logic                TxReady,
  output logic                IrqInChanged
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_port_out;
  logic [7:0]    r_sync1;
  logic [7:0]    r_in_sync;
  logic [7:0]    r_in_prev;
  logic          r_in_changed;
  logic          r_overflow;

  io_off_e       w_off;
  logic          w_hit;
  logic          w_rd;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_push_rej;
  logic [CW-1:0] w_count;
  logic          w_status_rd;
  logic          w_in_change;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_addr_unused;

  assign w_hit         = (bus.Address[31:4] == IO_BASE[31:4]);
  assign w_off         = io_off_e'(bus.Address[3:2]);
  assign w_addr_unused = ^bus.Address[1:0];
  assign w_rd          = w_hit & bus.MemRead;
  assign w_wr          = w_hit & bus.MemWrite;
  assign w_push        = w_wr & (w_off == OFF_TX_DATA);
  assign w_pop         = TxValid & TxReady;
  assign w_status_rd   = w_rd & (w_off == OFF_STATUS);
  assign w_in_change   = (r_in_sync != r_in_prev);

  io_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TX_WIDTH)
  ) u_tx_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (bus.WriteData[TX_WIDTH-1:0]),
    .i_pop       (w_pop),
    .o_data      (TxData),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_push_rej  (w_push_rej),
    .o_count     (w_count)
  );

  assign TxValid = ~w_empty;

  always_comb begin
    w_status = '0;
    w_status[STAT_IN_CHANGED] = r_in_changed;
    w_status[STAT_FULL]       = w_full;
    w_status[STAT_EMPTY]      = w_empty;
    w_status[STAT_OVERFLOW]   = r_overflow;
    w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_count);
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_off)
        OFF_PORT_OUT: w_rdata = r_port_out;
        OFF_PORT_IN:  w_rdata = {24'b0, r_in_sync};
        OFF_STATUS:   w_rdata = w_status;
        default:      w_rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = w_rdata;
  assign bus.Hit      = w_hit;
  assign PortOut      = r_port_out;
  assign IrqInChanged = r_in_changed;

  // Sticky flags: a set event on the same edge as a STATUS read wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_port_out   <= '0;
      r_sync1      <= '0;
      r_in_sync    <= '0;
      r_in_prev    <= '0;
      r_in_changed <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_sync1   <= PortIn;
      r_in_sync <= r_sync1;
      r_in_prev <= r_in_sync;
      if (w_wr && (w_off == OFF_PORT_OUT)) r_port_out <= bus.WriteData;
      r_in_changed <= w_in_change | (r_in_changed & ~w_status_rd);
      r_overflow   <= w_push_rej  | (r_overflow   & ~w_status_rd);
    end
  end
endmodule

// File: tb/tb_mips_io_responder.sv
// Directed self-checking bench for mips_io_responder.
module tb_mips_io_responder;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;
  logic        IrqInChanged;

  int n_vec = 0;
  int n_err = 0;

  mips_io_responder_if bus();

  mips_io_responder #(
    .IO_BASE    (BASE),
    .FIFO_DEPTH (4),
    .TX_WIDTH   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .PortIn       (PortIn),
    .PortOut      (PortOut),
    .TxData       (TxData),
    .TxValid      (TxValid),
    .TxReady      (TxReady),
    .IrqInChanged (IrqInChanged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.Address   = a;
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    bus.Address = a;
    bus.MemRead = 1'b1;
    #1;
    d = bus.ReadData;
    tick();
    bus.MemRead = 1'b0;
  endtask

  logic [31:0] rd;
  logic [7:0]  q[$];
  logic [7:0]  exp_seq [4];

  initial begin
    bus.Address   = '0;
    bus.WriteData = '0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    reset   = 1'b0;
    PortIn  = 8'h00;
    TxReady = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // 1: reset state, PORT_OUT write/read, decode miss
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_txvalid", {31'b0, TxValid}, 32'h0);
    chk("rst_irq", {31'b0, IrqInChanged}, 32'h0);
    bus.Address   = BASE;
    bus.WriteData = 32'hDEAD_BEEF;
    bus.MemWrite  = 1'b1;
    #1;
    chk("portout_pre_edge", PortOut, 32'h0);
    chk("hit_base", {31'b0, bus.Hit}, 32'h1);
    tick();
    bus.MemWrite = 1'b0;
    chk("portout_post_edge", PortOut, 32'hDEAD_BEEF);
    load(BASE, rd);
    chk("load_portout", rd, 32'hDEAD_BEEF);
    bus.Address = 32'h1001_0010;
    bus.MemRead = 1'b1;
    #1;
    chk("miss_hit", {31'b0, bus.Hit}, 32'h0);
    chk("miss_rdata", bus.ReadData, 32'h0);
    bus.MemRead = 1'b0;
    load(BASE + 32'h8, rd);
    chk("rst_status", rd, 32'h04);

    // 2: PortIn synchroniser and IN_CHANGED
    PortIn = 8'hA5;
    tick();
    bus.Address = BASE + 32'h4;
    bus.MemRead = 1'b1;
    #1;
    chk("portin_edge1", bus.ReadData, 32'h00);
    tick();
    chk("portin_edge2", bus.ReadData, 32'hA5);
    chk("irq_edge2", {31'b0, IrqInChanged}, 32'h0);
    tick();
    chk("irq_edge3", {31'b0, IrqInChanged}, 32'h1);
    bus.MemRead = 1'b0;
    load(BASE + 32'h8, rd);
    chk("status_changed", rd, 32'h05);
    load(BASE + 32'h8, rd);
    chk("status_cleared", rd, 32'h04);
    chk("irq_cleared", {31'b0, IrqInChanged}, 32'h0);
    PortIn = 8'h5A;
    tick();
    tick();
    load(BASE + 32'h8, rd);
    chk("status_read_on_set", rd, 32'h04);
    chk("set_wins_clear", {31'b0, IrqInChanged}, 32'h1);
    load(BASE + 32'h8, rd);
    chk("status_after_set", rd, 32'h05);

    // 3: fill, overflow, drain
    store(BASE + 32'hC, 32'h11);
    chk("fwft_head", {24'b0, TxData}, 32'h11);
    store(BASE + 32'hC, 32'h22);
    store(BASE + 32'hC, 32'h33);
    store(BASE + 32'hC, 32'h44);
    load(BASE + 32'h8, rd);
    chk("status_full", rd, 32'h42);
    store(BASE + 32'hC, 32'h55);
    load(BASE + 32'h8, rd);
    chk("status_overflow", rd, 32'h4A);
    load(BASE + 32'h8, rd);
    chk("overflow_cleared", rd, 32'h42);
    load(BASE + 32'hC, rd);
    chk("txdata_read_zero", rd, 32'h0);
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    TxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), {31'b0, TxValid}, 32'h1);
      chk($sformatf("drain_data%0d", i), {24'b0, TxData}, {24'b0, exp_seq[i]});
      tick();
    end
    chk("drained_valid", {31'b0, TxValid}, 32'h0);
    TxReady = 1'b0;
    load(BASE + 32'h8, rd);
    chk("status_empty", rd, 32'h04);

    // 4: push into full FIFO alongside a pop
    store(BASE + 32'hC, 32'hA1);
    store(BASE + 32'hC, 32'hA2);
    store(BASE + 32'hC, 32'hA3);
    store(BASE + 32'hC, 32'hA4);
    bus.Address   = BASE + 32'hC;
    bus.WriteData = 32'h66;
    bus.MemWrite  = 1'b1;
    TxReady       = 1'b1;
    tick();
    bus.MemWrite = 1'b0;
    TxReady      = 1'b0;
    load(BASE + 32'h8, rd);
    chk("full_push_pop_status", rd, 32'h42);
    exp_seq = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
    TxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fp_data%0d", i), {24'b0, TxData}, {24'b0, exp_seq[i]});
      tick();
    end
    chk("fp_drained", {31'b0, TxValid}, 32'h0);
    TxReady = 1'b0;

    // 5: hold under backpressure, then pointer wrap with push+pop pairs
    store(BASE + 32'hC, 32'h77);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_valid%0d", i), {31'b0, TxValid}, 32'h1);
      chk($sformatf("hold_data%0d", i), {24'b0, TxData}, 32'h77);
      tick();
    end
    q.delete();
    q.push_back(8'h77);
    for (int i = 0; i < 12; i++) begin
      bus.Address   = BASE + 32'hC;
      bus.WriteData = 32'h80 + i;
      bus.MemWrite  = 1'b1;
      TxReady       = 1'b1;
      #1;
      chk($sformatf("wrap_data%0d", i), {24'b0, TxData}, {24'b0, q[0]});
      tick();
      void'(q.pop_front());
      q.push_back(8'(8'h80 + i));
    end
    bus.MemWrite = 1'b0;
    chk("wrap_last", {24'b0, TxData}, {24'b0, q[0]});
    tick();
    chk("wrap_drained", {31'b0, TxValid}, 32'h0);
    TxReady = 1'b0;

    // 6: reset mid-transfer
    store(BASE, 32'h1234);
    store(BASE + 32'hC, 32'h01);
    store(BASE + 32'hC, 32'h02);
    store(BASE + 32'hC, 32'h03);
    load(BASE + 32'h8, rd);
    chk("pre_reset_status", rd, 32'h30);
    chk("pre_reset_portout", PortOut, 32'h1234);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("post_reset_valid", {31'b0, TxValid}, 32'h0);
    chk("post_reset_portout", PortOut, 32'h0);
    load(BASE + 32'h8, rd);
    chk("post_reset_status", rd, 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
